data_mem_responder: RTL and testbench

- Responder side of the processor's data-memory interface. It accepts load and store requests from a load/store initiator over a valid/ready request channel.
- Performs the access on an internal byte-addressed, little-endian memory after a fixed programmable latency.
- Returns a completion on a valid/ready response channel.
- Replaces the zero-latency data memory model so that pipelined cores can be exercised against realistic memory timing.

---
 rtl/data_mem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Responder side of the data-memory interface. Accepts one
//                load/store at a time over a valid/ready request channel,
//                performs it on an internal little-endian byte memory after
//                a fixed LATENCY, and returns a completion over a
//                valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int MEM_BYTES = 512,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int       AW        = $clog2(MEM_BYTES);
    localparam bit       ONE_CYCLE = (LATENCY == 1);
    localparam bit [3:0] CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   commit;

    logic [3:0]  count;

    logic        lat_write;
    logic [63:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [63:0] lat_wdata;

    logic        acc_write;
    logic [63:0] acc_addr;
    logic [1:0]  acc_size;
    logic        acc_unsigned;
    logic [63:0] acc_wdata;

    logic [7:0]    byte_en;
    logic [3:0]    nbytes;
    logic [2:0]    align_mask;
    logic [64:0]   end_addr;
    logic          acc_error;
    logic [AW-1:0] base;
    logic [63:0]   raw;
    logic [63:0]   load_val;

    logic [7:0] mem [MEM_BYTES];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; commit marks the edge on which the access happens
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (ONE_CYCLE) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (count == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latency counter: loaded on accept, counts down while busy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (state == IDLE && req_valid) begin
            count <= CNT_LOAD;
        end else if (state == BUSY && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write    <= 1'b0;
            lat_addr     <= 64'd0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_wdata    <= 64'd0;
        end else if (state == IDLE && req_valid) begin
            lat_write    <= req_write;
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
        end
    end

    // With single-cycle latency the access happens on the accept edge itself,
    // so the live request feeds the datapath while idle
    always_comb begin
        acc_write    = lat_write;
        acc_addr     = lat_addr;
        acc_size     = lat_size;
        acc_unsigned = lat_unsigned;
        acc_wdata    = lat_wdata;
        if (state == IDLE) begin
            acc_write    = req_write;
            acc_addr     = req_addr;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
            acc_wdata    = req_wdata;
        end
    end

    // Size decode, alignment and range checks (range sum kept 65 bits wide)
    always_comb begin
        byte_en    = 8'h01;
        nbytes     = 4'd1;
        align_mask = 3'b000;
        case (acc_size)
            2'd0: begin byte_en = 8'h01; nbytes = 4'd1; align_mask = 3'b000; end
            2'd1: begin byte_en = 8'h03; nbytes = 4'd2; align_mask = 3'b001; end
            2'd2: begin byte_en = 8'h0F; nbytes = 4'd4; align_mask = 3'b011; end
            default: begin byte_en = 8'hFF; nbytes = 4'd8; align_mask = 3'b111; end
        endcase
        end_addr  = {1'b0, acc_addr} + {61'd0, nbytes};
        acc_error = ((acc_addr[2:0] & align_mask) != 3'b000)
                    || (end_addr > 65'(MEM_BYTES));
        base      = acc_addr[AW-1:0];
    end

    // Gather eight bytes little-endian and extend to the access size
    always_comb begin
        raw = 64'd0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[base + AW'(i)];
        end
        case (acc_size)
            2'd0:    load_val = acc_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    load_val = acc_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_val = acc_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_val = raw;
        endcase
    end

    // Store commit; memory is not reset, and no commit while reset is held
    always_ff @(posedge clock) begin
        if (reset && commit && acc_write && !acc_error) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[base + AW'(i)] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers, captured on the commit edge and held until replaced
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= 64'd0;
            rsp_error <= 1'b0;
        end else if (commit) begin
            rsp_error <= acc_error;
            rsp_rdata <= (acc_error || acc_write) ? 64'd0 : load_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed scoreboard bench for data_mem_responder. Three
//                instances with LATENCY 2, 4 and 1 share one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        reset        [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_write    [3];
    logic [63:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [63:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [63:0] rsp_rdata    [3];
    logic        rsp_error    [3];

    int lat [3] = '{2, 4, 1};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            data_mem_responder #(
                .MEM_BYTES (512),
                .LATENCY   (g == 0 ? 2 : (g == 1 ? 4 : 1))
            ) u_dut (
                .clock        (clock),
                .reset        (reset[g]),
                .req_valid    (req_valid[g]),
                .req_ready    (req_ready[g]),
                .req_write    (req_write[g]),
                .req_addr     (req_addr[g]),
                .req_size     (req_size[g]),
                .req_unsigned (req_unsigned[g]),
                .req_wdata    (req_wdata[g]),
                .rsp_valid    (rsp_valid[g]),
                .rsp_ready    (rsp_ready[g]),
                .rsp_rdata    (rsp_rdata[g]),
                .rsp_error    (rsp_error[g])
            );
        end
    endgenerate

    int          passed = 0;
    int          total  = 0;
    int          acc_cyc [3];
    exp_t        sb [$];
    logic [7:0]  model [8];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive_req(int s, bit wr, logic [63:0] a, logic [1:0] sz, bit u, logic [63:0] wd);
        req_valid[s]    = 1'b1;
        req_write[s]    = wr;
        req_addr[s]     = a;
        req_size[s]     = sz;
        req_unsigned[s] = u;
        req_wdata[s]    = wd;
    endtask

    // acc_cyc holds the edge that opened the cycle in which the request was taken
    task automatic wait_accept(int s, string tag);
        int n = 0;
        while (!req_ready[s] && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready[s]) begin
            chk({tag, "_accept_timeout"}, 64'(req_ready[s]), 64'd1);
            req_valid[s] = 1'b0;
            return;
        end
        @(posedge clock); #1;
        acc_cyc[s]   = cyc - 1;
        req_valid[s] = 1'b0;
    endtask

    task automatic send(int s, bit wr, logic [63:0] a, logic [1:0] sz, bit u,
                        logic [63:0] wd, logic [63:0] er, bit ee, string tag);
        sb.push_back('{tag, er, ee});
        drive_req(s, wr, a, sz, u, wd);
        wait_accept(s, tag);
    endtask

    task automatic recv(int s, bit tied);
        exp_t e;
        int   n = 0;
        while (!rsp_valid[s] && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_valid"}, 64'(rsp_valid[s]), 64'd1);
        chk({e.tag, "_latency"}, 64'(cyc - acc_cyc[s]), 64'(lat[s]));
        chk({e.tag, "_rdata"}, rsp_rdata[s], e.rdata);
        chk({e.tag, "_error"}, 64'(rsp_error[s]), 64'(e.err));
        if (!tied) rsp_ready[s] = 1'b1;
        @(posedge clock); #1;
        if (!tied) rsp_ready[s] = 1'b0;
        chk({e.tag, "_valid_drop"}, 64'(rsp_valid[s]), 64'd0);
        chk({e.tag, "_ready_back"}, 64'(req_ready[s]), 64'd1);
    endtask

    function automatic logic [63:0] ref_load(int a, int sz, bit u);
        logic [63:0] v = 64'd0;
        int          n = 1 << sz;
        for (int i = 0; i < n; i++) v[8*i +: 8] = model[a + i];
        if (!u && sz < 3 && v[8*n - 1]) begin
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    initial begin
        exp_t        e;
        int          n;
        int          hs;
        int          prev;
        logic [63:0] wd;
        bit          u;

        for (int i = 0; i < 3; i++) begin
            reset[i]        = 1'b0;
            req_valid[i]    = 1'b0;
            req_write[i]    = 1'b0;
            req_addr[i]     = 64'd0;
            req_size[i]     = 2'd0;
            req_unsigned[i] = 1'b0;
            req_wdata[i]    = 64'd0;
            rsp_ready[i]    = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_req_ready", i), 64'(req_ready[i]), 64'd1);
            chk($sformatf("rst%0d_rsp_valid", i), 64'(rsp_valid[i]), 64'd0);
            chk($sformatf("rst%0d_rsp_rdata", i), rsp_rdata[i], 64'd0);
            chk($sformatf("rst%0d_rsp_error", i), 64'(rsp_error[i]), 64'd0);
            reset[i] = 1'b1;
        end
        @(posedge clock); #1;

        // ---------------- LATENCY = 2 instance ----------------
        send(0, 1, 64'h10, 2'd3, 0, 64'h1122334455667788, 64'd0, 0, "st_d_10");        recv(0, 0);
        send(0, 0, 64'h10, 2'd0, 0, 64'd0, 64'hFFFFFFFFFFFFFF88, 0, "ld_b_s");         recv(0, 0);
        send(0, 0, 64'h10, 2'd0, 1, 64'd0, 64'h0000000000000088, 0, "ld_b_u");         recv(0, 0);
        send(0, 0, 64'h16, 2'd1, 0, 64'd0, 64'h0000000000001122, 0, "ld_h_16");        recv(0, 0);
        send(0, 1, 64'h14, 2'd2, 0, 64'h00000000DEADBEEF, 64'd0, 0, "st_w_14");        recv(0, 0);
        send(0, 0, 64'h10, 2'd3, 0, 64'd0, 64'hDEADBEEF55667788, 0, "ld_d_10");        recv(0, 0);
        send(0, 0, 64'h12, 2'd2, 0, 64'd0, 64'd0, 1, "ld_w_misalign");                 recv(0, 0);
        send(0, 0, 64'h1FC, 2'd3, 0, 64'd0, 64'd0, 1, "ld_d_oor");                     recv(0, 0);
        send(0, 1, 64'h12, 2'd2, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, "st_w_misalign");  recv(0, 0);
        send(0, 1, 64'hFFFFFFFFFFFFFFF8, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, "st_d_wrap"); recv(0, 0);
        send(0, 0, 64'h10, 2'd3, 0, 64'd0, 64'hDEADBEEF55667788, 0, "ld_d_unchanged"); recv(0, 0);
        send(0, 0, 64'h14, 2'd2, 0, 64'd0, 64'hFFFFFFFFDEADBEEF, 0, "ld_w_s");         recv(0, 0);
        send(0, 0, 64'h14, 2'd2, 1, 64'd0, 64'h00000000DEADBEEF, 0, "ld_w_u");         recv(0, 0);
        send(0, 1, 64'h1F8, 2'd3, 0, 64'h0123456789ABCDEF, 64'd0, 0, "st_d_top");      recv(0, 0);
        send(0, 0, 64'h1FE, 2'd1, 0, 64'd0, 64'h0000000000000123, 0, "ld_h_top");     recv(0, 0);

        // Backpressure with a second request waiting throughout
        send(0, 0, 64'h10, 2'd3, 0, 64'd0, 64'hDEADBEEF55667788, 0, "bp_a");
        sb.push_back('{"bp_b", 64'hFFFFFFFFFFFFBEEF, 1'b0});
        drive_req(0, 0, 64'h14, 2'd1, 0, 64'd0);
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        e = sb.pop_front();
        chk("bp_a_valid", 64'(rsp_valid[0]), 64'd1);
        chk("bp_a_rdata", rsp_rdata[0], e.rdata);
        chk("bp_a_error", 64'(rsp_error[0]), 64'(e.err));
        repeat (5) begin
            @(posedge clock); #1;
            chk("bp_hold_valid", 64'(rsp_valid[0]), 64'd1);
            chk("bp_hold_rdata", rsp_rdata[0], e.rdata);
            chk("bp_hold_error", 64'(rsp_error[0]), 64'(e.err));
            chk("bp_hold_req_ready", 64'(req_ready[0]), 64'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clock); #1;
        rsp_ready[0] = 1'b0;
        hs = cyc;
        chk("bp_a_valid_drop", 64'(rsp_valid[0]), 64'd0);
        wait_accept(0, "bp_b");
        chk("bp_b_accept_edge", 64'(acc_cyc[0] + 1), 64'(hs + 1));
        recv(0, 0);

        // ---------------- LATENCY = 4 instance: reset mid-store ----------------
        send(1, 1, 64'h20, 2'd0, 0, 64'h55, 64'd0, 0, "l4_st_b_55");  recv(1, 0);
        send(1, 0, 64'h20, 2'd0, 1, 64'd0, 64'h55, 0, "l4_ld_b_55");  recv(1, 0);
        drive_req(1, 1, 64'h20, 2'd0, 0, 64'hAA);
        wait_accept(1, "l4_st_aa");
        @(posedge clock); #1;
        chk("l4_busy_req_ready", 64'(req_ready[1]), 64'd0);
        reset[1] = 1'b0;
        #1;
        chk("l4_rst_req_ready", 64'(req_ready[1]), 64'd1);
        chk("l4_rst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk("l4_rst_rsp_rdata", rsp_rdata[1], 64'd0);
        chk("l4_rst_rsp_error", 64'(rsp_error[1]), 64'd0);
        repeat (4) @(posedge clock);
        #1;
        reset[1] = 1'b1;
        @(posedge clock); #1;
        send(1, 0, 64'h20, 2'd0, 1, 64'd0, 64'h55, 0, "l4_ld_after_rst"); recv(1, 0);

        // ---------------- LATENCY = 1 instance: back-to-back sweep ----------------
        rsp_ready[2] = 1'b1;
        wd = 64'hF1E2D3C4B5A69788;
        send(2, 1, 64'h0, 2'd3, 0, wd, 64'd0, 0, "l1_init"); recv(2, 1);
        for (int i = 0; i < 8; i++) model[i] = wd[8*i +: 8];
        prev = acc_cyc[2];
        for (int sz = 0; sz < 4; sz++) begin
            for (int off = 0; off < 8; off += (1 << sz)) begin
                wd = {$urandom, $urandom};
                send(2, 1, 64'(off), 2'(sz), 0, wd, 64'd0, 0, $sformatf("l1_st_s%0d_o%0d", sz, off));
                chk("l1_spacing", 64'(acc_cyc[2] - prev), 64'd2);
                prev = acc_cyc[2];
                recv(2, 1);
                for (int i = 0; i < (1 << sz); i++) model[off + i] = wd[8*i +: 8];
                u = 1'($urandom_range(0, 1));
                send(2, 0, 64'(off), 2'(sz), u, 64'd0, ref_load(off, sz, u), 0,
                     $sformatf("l1_ld_s%0d_o%0d_u%0d", sz, off, u));
                chk("l1_spacing", 64'(acc_cyc[2] - prev), 64'd2);
                prev = acc_cyc[2];
                recv(2, 1);
                send(2, 0, 64'h0, 2'd3, 0, 64'd0, ref_load(0, 3, 0), 0,
                     $sformatf("l1_ld_all_s%0d_o%0d", sz, off));
                chk("l1_spacing", 64'(acc_cyc[2] - prev), 64'd2);
                prev = acc_cyc[2];
                recv(2, 1);
            end
        end
        rsp_ready[2] = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
